// File: rtl/unet_ip_relu_requant.sv
`default_nettype none
// ============================================================================
//  Module      : unet_ip_relu_requant
//  Description : Streams a CHW feature map out of the conv accumulator buffer,
//                applies ReLU, an arithmetic requantize right-shift and an
//                unsigned upper clamp, then writes the result into the
//                activation buffer read by the maxpool stage. One element per
//                cycle, three-stage read/register/write pipeline.
//  Revision    : 1.0 - initial release
// ============================================================================
module unet_ip_relu_requant (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [6:0]  channels,
  input  logic [6:0]  height,
  input  logic [6:0]  width,
  input  logic [2:0]  shift,
  input  logic [11:0] cap,
  output logic [14:0] input_rsc_radr,
  output logic        input_rsc_re,
  input  logic [11:0] input_rsc_q,
  output logic        input_rsc_clken,
  output logic        input_triosy_lz,
  output logic [14:0] output_rsc_wadr,
  output logic [11:0] output_rsc_d,
  output logic        output_rsc_we,
  output logic        output_rsc_clken,
  output logic        output_triosy_lz,
  output logic        busy,
  output logic        done,
  output logic        err
);

  // Largest feature map the 15-bit address space can hold.
  localparam logic [20:0] c_MAX_ELEMS = 21'd32768;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t      r_state;

  // Parameters captured when a run is accepted.
  logic [14:0] r_last;
  logic [2:0]  r_shift;
  logic [11:0] r_cap;

  // Read side (stage 1).
  logic [14:0] r_radr;
  logic        r_re;

  // Read-data return stage (stage 2): tracks which address q belongs to.
  logic        r_rd_vld;
  logic [14:0] r_rd_adr;

  // Write side (stage 3).
  logic [14:0] r_wadr;
  logic [11:0] r_d;
  logic        r_we;

  // Status.
  logic        r_busy;
  logic        r_done;
  logic        r_err;

  // Element count at full width so oversized maps cannot alias into range.
  logic [20:0] w_n;
  logic        w_valid;
  logic [14:0] w_last;

  // Datapath.
  logic [10:0] w_shifted;
  logic [11:0] w_relu;
  logic [11:0] w_d;

  assign w_n     = 21'(channels) * 21'(height) * 21'(width);
  assign w_valid = (channels != 7'd0) && (height != 7'd0) && (width != 7'd0)
                   && (w_n <= c_MAX_ELEMS);
  // Only the low 15 bits matter once N is known valid; N=32768 yields 0-1=32767.
  assign w_last  = w_n[14:0] - 15'd1;

  // Negative values clamp to zero, so only the 11 magnitude bits of a
  // non-negative sample are ever shifted; the result never exceeds 2047.
  assign w_shifted = input_rsc_q[10:0] >> r_shift;
  assign w_relu    = input_rsc_q[11] ? 12'd0 : {1'b0, w_shifted};
  assign w_d       = (w_relu > r_cap) ? r_cap : w_relu;

  // Control FSM: parameter capture, read address generation and status pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_last  <= 15'd0;
      r_shift <= 3'd0;
      r_cap   <= 12'd0;
      r_radr  <= 15'd0;
      r_re    <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            if (w_valid) begin
              r_last  <= w_last;
              r_shift <= shift;
              r_cap   <= cap;
              r_err   <= 1'b0;
              r_re    <= 1'b1;
              r_radr  <= 15'd0;
              r_busy  <= 1'b1;
              r_state <= ST_RUN;
            end else begin
              // Rejected run: no memory traffic, report straight away.
              r_err   <= 1'b1;
              r_done  <= 1'b1;
              r_state <= ST_DONE;
            end
          end
        end
        ST_RUN: begin
          if (r_radr == r_last) begin
            // Final read has been issued; park the address at zero.
            r_re    <= 1'b0;
            r_radr  <= 15'd0;
            r_state <= ST_DRAIN;
          end else begin
            r_radr  <= r_radr + 15'd1;
          end
        end
        ST_DRAIN: begin
          // The pipeline is empty once no read data is in flight; the write
          // being presented this cycle is the last one.
          if (!r_rd_vld) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Pipeline: remember the read address for the returning data, then write
  // the requantized value one cycle later. Idle cycles drive zeros.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_vld <= 1'b0;
      r_rd_adr <= 15'd0;
      r_we     <= 1'b0;
      r_wadr   <= 15'd0;
      r_d      <= 12'd0;
    end else begin
      r_rd_vld <= r_re;
      r_rd_adr <= r_radr;
      r_we     <= r_rd_vld;
      r_wadr   <= r_rd_vld ? r_rd_adr : 15'd0;
      r_d      <= r_rd_vld ? w_d : 12'd0;
    end
  end

  assign input_rsc_radr   = r_radr;
  assign input_rsc_re     = r_re;
  assign input_rsc_clken  = r_busy;
  assign input_triosy_lz  = r_done;
  assign output_rsc_wadr  = r_wadr;
  assign output_rsc_d     = r_d;
  assign output_rsc_we    = r_we;
  assign output_rsc_clken = r_busy;
  assign output_triosy_lz = r_done;
  assign busy             = r_busy;
  assign done             = r_done;
  assign err              = r_err;

endmodule
`default_nettype wire

// File: tb/tb_unet_ip_relu_requant.sv
`default_nettype none
// ============================================================================
//  Module      : tb_unet_ip_relu_requant
//  Description : Scoreboard bench for unet_ip_relu_requant. Each run pushes the
//                expected reads, writes and completion into queues; a monitor
//                on the falling edge pops and compares whatever the DUT shows.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_unet_ip_relu_requant;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [6:0]  channels, height, width;
  logic [2:0]  shift;
  logic [11:0] cap;
  logic [14:0] radr, wadr;
  logic        re, we, in_clken, out_clken, in_triosy, out_triosy;
  logic        busy, done, err;
  logic [11:0] q, d;

  always #5 clk = ~clk;

  unet_ip_relu_requant dut (
    .clk(clk), .rst(rst), .start(start),
    .channels(channels), .height(height), .width(width),
    .shift(shift), .cap(cap),
    .input_rsc_radr(radr), .input_rsc_re(re), .input_rsc_q(q),
    .input_rsc_clken(in_clken), .input_triosy_lz(in_triosy),
    .output_rsc_wadr(wadr), .output_rsc_d(d), .output_rsc_we(we),
    .output_rsc_clken(out_clken), .output_triosy_lz(out_triosy),
    .busy(busy), .done(done), .err(err)
  );

  // Source memory: data appears the cycle after a read; garbage otherwise.
  logic [11:0] mem [0:32767];
  always @(posedge clk) begin
    if (re) q <= mem[radr];
    else    q <= 12'($urandom);
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed { int a; int v; int c; } ev_t;
  ev_t rdq[$];
  ev_t wrq[$];
  ev_t dnq[$];   // a = expected err, c = expected cycle
  int  busy_from = 1;
  int  busy_to   = 0;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h cycle=%0d", nm, act, exp, cyc);
  endtask

  // Reference behaviour: ReLU, floor-divide by 2^S, clamp to cap.
  function automatic int ref_d(input logic [11:0] raw, input int s, input int cp);
    int v;
    v = int'($signed(raw));
    if (v < 0) return 0;
    v = v / (1 << s);
    return (v > cp) ? cp : v;
  endfunction

  // Falling-edge monitor.
  always @(negedge clk) begin
    ev_t e;
    if (re) begin
      if (rdq.size() == 0) chk("unexpected_read", {49'd0, radr}, 64'hFFFF);
      else begin
        e = rdq.pop_front();
        chk("read_addr", 64'(radr), 64'(e.a));
        chk("read_cycle", 64'(cyc), 64'(e.c));
      end
    end else chk("radr_idle_zero", 64'(radr), 64'd0);
    if (we) begin
      if (wrq.size() == 0) chk("unexpected_write", {49'd0, wadr}, 64'hFFFF);
      else begin
        e = wrq.pop_front();
        chk("write_addr", 64'(wadr), 64'(e.a));
        chk("write_data", 64'(d), 64'(e.v));
        chk("write_cycle", 64'(cyc), 64'(e.c));
      end
    end else begin
      chk("wadr_idle_zero", 64'(wadr), 64'd0);
      chk("d_idle_zero", 64'(d), 64'd0);
    end
    if (done) begin
      if (dnq.size() == 0) chk("unexpected_done", 64'd1, 64'd0);
      else begin
        e = dnq.pop_front();
        chk("done_cycle", 64'(cyc), 64'(e.c));
        chk("err_at_done", 64'(err), 64'(e.a));
      end
    end
    chk("busy", 64'(busy), 64'(cyc >= busy_from && cyc <= busy_to));
    chk("in_clken", 64'(in_clken), 64'(busy));
    chk("out_clken", 64'(out_clken), 64'(busy));
    chk("in_triosy", 64'(in_triosy), 64'(done));
    chk("out_triosy", 64'(out_triosy), 64'(done));
  end

  function automatic logic [63:0] all_outs();
    return 64'({radr, re, in_clken, in_triosy, wadr, d, we, out_clken,
                out_triosy, busy, done, err});
  endfunction

  // One run, issued in the current cycle (caller is just after a rising edge).
  task automatic run(input int c, input int h, input int w, input int s, input int cp,
                     input bit fill, input int abort_at, input bit repulse);
    int  n, t0, nr, nw;
    bit  valid;
    n     = c * h * w;
    valid = (c != 0) && (h != 0) && (w != 0) && (n <= 32768);
    if (fill && valid) for (int a = 0; a < n; a++) mem[a] = 12'($urandom);
    t0 = cyc;
    if (valid) begin
      nr = (abort_at != 0 && abort_at < n) ? abort_at : n;
      nw = (abort_at != 0 && abort_at - 2 < n) ? abort_at - 2 : n;
      for (int a = 0; a < nr; a++) rdq.push_back('{a: a, v: 0, c: t0 + 1 + a});
      for (int a = 0; a < nw; a++)
        wrq.push_back('{a: a, v: ref_d(mem[a], s, cp), c: t0 + 3 + a});
      busy_from = t0 + 1;
      busy_to   = (abort_at != 0) ? t0 + abort_at : t0 + n + 2;
      if (abort_at == 0) dnq.push_back('{a: 0, v: 0, c: t0 + n + 3});
    end else begin
      busy_from = 1;
      busy_to   = 0;
      dnq.push_back('{a: 1, v: 0, c: t0 + 1});
    end
    channels = 7'(c); height = 7'(h); width = 7'(w); shift = 3'(s); cap = 12'(cp);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("err_after_start", 64'(err), 64'(!valid));
    if (abort_at != 0) begin
      while (cyc < t0 + abort_at) begin @(posedge clk); #1; end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("outputs_after_rst", all_outs(), 64'd0);
      repeat (20) begin @(posedge clk); #1; end
    end else begin
      for (int k = 0; k < n + 20 && dnq.size() != 0; k++) begin
        if (repulse && cyc == t0 + 5) begin
          start    = 1'b1;
          channels = 7'($urandom); height = 7'($urandom); width = 7'($urandom);
          shift    = 3'($urandom); cap = 12'($urandom);
        end else start = 1'b0;
        @(posedge clk); #1;
      end
      start = 1'b0;
      chk("done_timeout", 64'(dnq.size()), 64'd0);
      if (dnq.size() != 0) begin
        rdq.delete(); wrq.delete(); dnq.delete();
        busy_from = 1; busy_to = 0;
        rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
      end
      if (!valid) chk("err_sticky", 64'(err), 64'd1);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0;
    channels = '0; height = '0; width = '0; shift = '0; cap = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", all_outs(), 64'd0);
    rst = 1'b0;

    // Mixed-sign values at full cap, no shift.
    mem[0] = 12'd5; mem[1] = 12'hFFD; mem[2] = 12'd2047; mem[3] = 12'h800;
    run(1, 2, 2, 0, 4095, 1'b0, 0, 1'b0);
    // Shift plus clamp.
    mem[0] = 12'd400; mem[1] = 12'd1000; mem[2] = 12'd7; mem[3] = 12'hFFF;
    run(1, 1, 4, 2, 100, 1'b0, 0, 1'b0);
    // Oversized map rejected, then a valid run clears err.
    run(64, 23, 23, 0, 4095, 1'b0, 0, 1'b0);
    run(2, 3, 3, 1, 2000, 1'b1, 0, 1'b0);
    run(0, 5, 5, 0, 100, 1'b0, 0, 1'b0);
    run(3, 3, 3, 3, 0, 1'b1, 0, 1'b0);
    // Randomized runs.
    for (int i = 0; i < 8; i++)
      run(int'($urandom_range(1, 4)), int'($urandom_range(1, 8)), int'($urandom_range(1, 8)),
          int'($urandom_range(0, 7)), int'($urandom_range(0, 4095)), 1'b1, 0, 1'b0);
    // Start re-pulsed mid-run, then back-to-back runs.
    run(1, 4, 8, 1, 900, 1'b1, 0, 1'b1);
    run(2, 2, 5, 0, 4095, 1'b1, 0, 1'b0);
    run(1, 3, 3, 4, 50, 1'b1, 0, 1'b0);
    // Reset in cycle 10 of a 16-element run.
    run(1, 4, 4, 0, 4095, 1'b1, 10, 1'b0);
    // First start after that reset, then the largest legal map.
    run(1, 2, 3, 2, 3000, 1'b1, 0, 1'b0);
    run(8, 64, 64, int'($urandom_range(0, 7)), int'($urandom_range(0, 4095)), 1'b1, 0, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    chk("pending_reads", 64'(rdq.size()), 64'd0);
    chk("pending_writes", 64'(wrq.size()), 64'd0);
    chk("pending_done", 64'(dnq.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/unet_ip_relu_requant.md
UNET_IP_RELU_REQUANT -- requirements
Module: unet_ip_relu_requant

Interface
REQ-001 SHALL have exactly one clock and a synchronous, active-high reset: clk (clock) and rst (synchronous, active-high reset); there is no asynchronous reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 start  input  1  one-cycle request to process a feature map; sampled only in IDLE.
REQ-005 channels  input  7  channel count C, latched on accepted start.
REQ-006 height  input  7  row count H, latched on accepted start.
REQ-007 width  input  7  column count W, latched on accepted start.
REQ-008 shift  input  3  requantize right-shift S, 0..7, latched on accepted start.
REQ-009 cap  input  12  unsigned upper clamp value, latched on accepted start.
REQ-010 input_rsc_radr  output  15  read address into the conv accumulator buffer.
REQ-011 input_rsc_re  output  1  read enable.
REQ-012 input_rsc_q  input  12  signed two's-complement read data, valid in the cycle after re.
REQ-013 input_rsc_clken  output  1  input memory clock enable.
REQ-014 input_triosy_lz  output  1  input-done pulse.
REQ-015 output_rsc_wadr  output  15  write address into the activation buffer read by the maxpool stage.
REQ-016 output_rsc_d  output  12  write data, unsigned.
REQ-017 output_rsc_we  output  1  write enable.
REQ-018 output_rsc_clken  output  1  output memory clock enable.
REQ-019 output_triosy_lz  output  1  output-done pulse.
REQ-020 busy  output  1  high in RUN and DRAIN.
REQ-021 done  output  1  one-cycle completion pulse.
REQ-022 err  output  1  sticky parameter error; cleared by the next accepted start or by rst.

Function
REQ-023 Layout SHALL be CHW-contiguous, addr = c*H*W + y*W + x; the block SHALL traverse flat addresses 0..N-1, where N = C*H*W is computed at full 21-bit width.
REQ-024 FSM states SHALL be IDLE, RUN, DRAIN, DONE.
- IDLE -> RUN on start with a valid N.
- RUN -> DRAIN after issuing read N-1.
- DRAIN -> DONE once the last write has completed.
- DONE -> IDLE unconditionally after one cycle.
REQ-025 Parameters are invalid when C=0, H=0, W=0 or N>32768; start with invalid parameters SHALL go IDLE -> DONE, perform no memory access, and set err=1 in the DONE cycle.
REQ-026 Start asserted outside IDLE SHALL be ignored, and the latched parameters SHALL stay unchanged.
REQ-027 In RUN, re SHALL be 1 every cycle, and radr SHALL increment by 1 per cycle starting at 0; throughput SHALL be 1 element per cycle with no bubbles.
REQ-028 Pipeline: a read issued in cycle t returns q in t+1, which SHALL be registered. we=1 in cycle t+2, with wadr equal to the radr of cycle t.
REQ-029 Data path: v = signed q.
- If v<0, then r=0; otherwise r = v >> S (logical shift; maximum 2047).
- d = min(r, cap), compared unsigned.
REQ-030 Timing from start sampled high in cycle 0:
- re high in cycles 1..N;
- we high in cycles 3..N+2;
- done, input_triosy_lz and output_triosy_lz high only in cycle N+3;
- state is IDLE in cycle N+4.
REQ-031 input_rsc_clken and output_rsc_clken SHALL be 1 exactly while busy=1.
REQ-032 radr SHALL hold 0 when re=0, and wadr and d SHALL hold 0 when we=0.
REQ-033 The block SHALL never issue a read address above N-1 and SHALL never write the same address twice in one run.
REQ-034 N=32768 is valid; the final radr of 32767 SHALL not wrap.
REQ-035 start may be accepted in the IDLE cycle immediately after DONE (back-to-back runs).

Reset
REQ-036 While rst=1, the state SHALL be IDLE at the next edge, and every output SHALL be 0 (busy, done, err, re, we, both clken, both triosy, addresses, d).
REQ-037 Reset during RUN or DRAIN SHALL abort the run: no write SHALL occur in any cycle after the rst cycle, and no done pulse SHALL occur.
REQ-038 The first start after rst deasserts SHALL be honoured.

Verification
REQ-039 C=1, H=2, W=2, S=0, cap=4095, memory [5,-3,2047,-2048] -> writes [5,0,2047,0] at addresses 0..3 in cycles 3..6, done in cycle 7.
REQ-040 S=2, cap=100, q in {400,1000,7,-1} -> d in {100,100,1,0}.
REQ-041 C=64, H=W=23 (N=33856) -> no re/we, err=1 and done in cycle 1; a following valid start clears err.
REQ-042 C=8, H=W=64 (N=32768) -> last radr 32767, last write in cycle 32770, done in cycle 32771.
REQ-043 rst asserted in cycle 10 of an N=16 run -> we=0 from cycle 11 onward, no done pulse, all outputs 0.
REQ-044 start re-pulsed during RUN -> ignored, with identical write trace; start in the IDLE cycle after done -> second run begins with re in the following cycle.
